ch_cond_wb: RTL

Input conditioning stage directly upstream of the clock-counter block. It takes the raw, asynchronous start/stop channel pins and registers them into the clk_i domain. It glitch-filters each channel, applies per-channel polarity and enable masks, and drives the conditioned active-low levels the counter consumes on ch_in. Configuration and edge status are exposed through the same 8-bit Wishbone slave style as the counter.

---
 rtl/ch_cond_wb_pkg.sv | 23 ++
 rtl/ch_filter.sv | 59 +++++
 rtl/ch_cond_wb.sv | 115 +++++++++++
 3 files changed

// File: rtl/ch_cond_wb_pkg.sv
// Shared constants for the channel input conditioning block.
// Holds the register map, reset values and a helper that builds low-bit masks.
package ch_cond_wb_pkg;

   localparam logic [3:0] CC_EN     = 4'h0;
   localparam logic [3:0] CC_POL    = 4'h1;
   localparam logic [3:0] CC_FILT   = 4'h2;
   localparam logic [3:0] CC_STICKY = 4'h3;
   localparam logic [3:0] CC_RAW    = 4'h4;

   localparam logic [7:0] EN_RST   = 8'hFF;
   localparam logic [7:0] POL_RST  = 8'h00;
   localparam logic [7:0] FILT_RST = 8'h00;

   // Mask with the lowest n bits set; saturates at a full byte.
   function automatic logic [7:0] lowMask(input int unsigned n);
      if (n >= 8)
         lowMask = 8'hFF;
      else
         lowMask = 8'((16'd1 << n) - 16'd1);
   endfunction

endpackage

// File: rtl/ch_filter.sv
// One channel: synchronizer chain, then a persistence filter.
// A new level has to be seen filtLen_i+1 cycles in a row before it replaces f_o.
module ch_filter #(
   parameter int FILT_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pin_i,
   input  logic [FILT_W-1:0] filtLen_i,
   input  logic              en_i,
   output logic              s_o,
   output logic              f_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   fState_q, fState_d;
   logic [FILT_W-1:0]      cnt_q, cnt_d;

   assign s_o = sync_q[SYNC_STAGES-1];
   assign f_o = fState_q;

   // Shift the raw pin through the synchronizer; idles high like an inactive pin.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         sync_q <= '1;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   // Filter decision; >= so a shortened length mid-count commits at once rather than wrapping.
   always_comb begin
      fState_d = fState_q;
      cnt_d    = cnt_q;
      if (!en_i) begin
         fState_d = s_o;
         cnt_d    = '0;
      end else if (s_o == fState_q) begin
         cnt_d = '0;
      end else if (cnt_q >= filtLen_i) begin
         fState_d = s_o;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + FILT_W'(1);
      end
   end

   // Filter state register; reset discards any count in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fState_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         fState_q <= fState_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ch_cond_wb.sv
// Channel input conditioning ahead of the clock counter.
// Per-channel sync and glitch filter, polarity/enable masking, edge detect,
// sticky edge status, all configured through an 8-bit Wishbone-style slave.
module ch_cond_wb
   import ch_cond_wb_pkg::*;
#(
   parameter int NCH         = 6,
   parameter int FILT_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [7:0]     dat_i,
   input  logic [5:2]     adr_i,
   output logic [7:0]     dat_o,
   input  logic           stb_i,
   input  logic           we_i,
   output logic           ack_o,
   input  logic [NCH-1:0] pin_in,
   output logic [NCH-1:0] ch_out,
   output logic [NCH-1:0] ch_edge
);

   localparam logic [7:0] CH_MASK   = lowMask(NCH);
   localparam logic [7:0] FILT_MASK = lowMask(FILT_W);

   logic [7:0]     enMask_q, enMask_d;
   logic [7:0]     polMask_q, polMask_d;
   logic [7:0]     filtLen_q, filtLen_d;
   logic [7:0]     sticky_q, sticky_d;
   logic [7:0]     rdData_q, rdData_d;
   logic [7:0]     rdMux;
   logic [7:0]     w1cMask;
   logic           ack_q;
   logic           wrStb, rdStb;
   logic [NCH-1:0] rawSync;
   logic [NCH-1:0] filtLevel;
   logic [NCH-1:0] chOutPrev_q;
   logic [NCH-1:0] chEdge_q;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      ch_filter #(
         .FILT_W      (FILT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_filter (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .pin_i     (pin_in[i]),
         .filtLen_i (filtLen_q[FILT_W-1:0]),
         .en_i      (enMask_q[i]),
         .s_o       (rawSync[i]),
         .f_o       (filtLevel[i])
      );
   end

   // Disabled channels park high; enabled ones pass the filtered level, optionally inverted.
   assign ch_out  = ~enMask_q[NCH-1:0] | (filtLevel ^ polMask_q[NCH-1:0]);
   assign ch_edge = chEdge_q;
   assign ack_o   = ack_q;
   assign dat_o   = rdData_q;

   // Bus decode, register next-state and read mux; an edge beats a same-cycle clear.
   always_comb begin
      wrStb     = stb_i & we_i;
      rdStb     = stb_i & ~we_i;
      enMask_d  = enMask_q;
      polMask_d = polMask_q;
      filtLen_d = filtLen_q;
      w1cMask   = 8'h00;
      rdMux     = 8'h00;
      if (wrStb) begin
         case (adr_i)
            CC_EN:     enMask_d  = dat_i & CH_MASK;
            CC_POL:    polMask_d = dat_i & CH_MASK;
            CC_FILT:   filtLen_d = dat_i & FILT_MASK;
            CC_STICKY: w1cMask   = dat_i & CH_MASK;
            default:   ;
         endcase
      end
      case (adr_i)
         CC_EN:     rdMux = enMask_q;
         CC_POL:    rdMux = polMask_q;
         CC_FILT:   rdMux = filtLen_q;
         CC_STICKY: rdMux = sticky_q;
         CC_RAW:    rdMux = 8'(rawSync);
         default:   rdMux = 8'h00;
      endcase
      sticky_d = (sticky_q & ~w1cMask) | 8'(chEdge_q);
      rdData_d = rdStb ? rdMux : rdData_q;
   end

   // Registers, bus response and the falling-edge detector.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enMask_q    <= EN_RST & CH_MASK;
         polMask_q   <= POL_RST & CH_MASK;
         filtLen_q   <= FILT_RST & FILT_MASK;
         sticky_q    <= 8'h00;
         rdData_q    <= 8'h00;
         ack_q       <= 1'b0;
         chOutPrev_q <= '1;
         chEdge_q    <= '0;
      end else begin
         enMask_q    <= enMask_d;
         polMask_q   <= polMask_d;
         filtLen_q   <= filtLen_d;
         sticky_q    <= sticky_d;
         rdData_q    <= rdData_d;
         ack_q       <= stb_i;
         chOutPrev_q <= ch_out;
         chEdge_q    <= chOutPrev_q & ~ch_out;
      end
   end

endmodule
